// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the BNN classifier engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L0   = 2'd1,
        S_L1   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Signed accumulator width: magnitude of FEAT_CNT*(2^FEAT_BITS-1) plus a sign bit.
    function automatic int accw(input int feat_cnt, input int feat_bits);
        return feat_bits + $clog2(feat_cnt) + 1;
    endfunction

    // Width able to hold a popcount of n bits (0..n).
    function automatic int popw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bnn_neuron0.sv
// One first-layer lane: signed +/-x accumulate over all features, then sign.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when the result is captured.
module bnn_neuron0
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT  = 16,
    parameter int FEAT_BITS = 4
) (
    input  logic [FEAT_CNT*FEAT_BITS-1:0] feat_i,
    input  logic [FEAT_CNT-1:0]           w_i,
    output logic                          h_o
);

    localparam int AW = accw(FEAT_CNT, FEAT_BITS);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] xe;

    // Weight 1 adds the unsigned feature, weight 0 subtracts it.
    always_comb begin
        acc = '0;
        xe  = '0;
        for (int f = 0; f < FEAT_CNT; f++) begin
            xe                 = '0;
            xe[FEAT_BITS-1:0]  = feat_i[f*FEAT_BITS +: FEAT_BITS];
            if (w_i[f]) acc = acc + xe;
            else        acc = acc - xe;
        end
    end

    // Zero accumulates count as positive.
    assign h_o = ~acc[AW-1];

endmodule

// File: rtl/bnn_romex_pipe.sv
// Sequential 2-layer BNN classifier: PAR hidden neurons per cycle, then one class per cycle with argmax.
// Latency: out_valid rises ceil(HIDDEN_CNT/PAR)+CLASS_CNT cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until the result is taken.
module bnn_romex_pipe
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT   = 16,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int PAR        = 4,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  Weights0 = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights1 = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]      prediction,
    output logic [$clog2(HIDDEN_CNT+1)-1:0]   score
);

    localparam int FW     = FEAT_CNT * FEAT_BITS;
    localparam int L0_CYC = (HIDDEN_CNT + PAR - 1) / PAR;
    localparam int CMAX   = (L0_CYC > CLASS_CNT) ? L0_CYC : CLASS_CNT;
    localparam int CW     = $clog2(CMAX);
    localparam int PW     = $clog2(CLASS_CNT);
    localparam int SW     = popw(HIDDEN_CNT);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FW-1:0]        feat_q, feat_d;
    logic [HIDDEN_CNT-1:0] hid_q, hid_d;
    logic [PW-1:0]        best_idx_q, best_idx_d;
    logic [SW-1:0]        best_sc_q, best_sc_d;
    logic [PW-1:0]        pred_q, pred_d;
    logic [SW-1:0]        score_q, score_d;

    logic [FEAT_CNT-1:0]   lane_w [PAR];
    logic [PAR-1:0]        lane_h;
    logic [HIDDEN_CNT-1:0] cls_w;
    logic [SW-1:0]         cls_sc;
    logic                  take;

    // Route the weight row of neuron cnt*PAR+p to lane p; lanes past the last neuron see zeros.
    always_comb begin
        for (int p = 0; p < PAR; p++) begin
            lane_w[p] = '0;
            for (int n = 0; n < HIDDEN_CNT; n++) begin
                if (n == int'(cnt_q) * PAR + p) lane_w[p] = Weights0[n*FEAT_CNT +: FEAT_CNT];
            end
        end
    end

    for (genvar p = 0; p < PAR; p++) begin : g_lane
        bnn_neuron0 #(
            .FEAT_CNT  (FEAT_CNT),
            .FEAT_BITS (FEAT_BITS)
        ) u_lane (
            .feat_i (feat_q),
            .w_i    (lane_w[p]),
            .h_o    (lane_h[p])
        );
    end

    // XNOR-popcount of the hidden vector against the current class row; class 0 always seeds the max.
    always_comb begin
        cls_w  = '0;
        cls_sc = '0;
        for (int c = 0; c < CLASS_CNT; c++) begin
            if (c == int'(cnt_q)) cls_w = Weights1[c*HIDDEN_CNT +: HIDDEN_CNT];
        end
        for (int n = 0; n < HIDDEN_CNT; n++) begin
            cls_sc = cls_sc + SW'(hid_q[n] ~^ cls_w[n]);
        end
        take = (cnt_q == '0) || (cls_sc > best_sc_q);
    end

    // FSM next state, counters, hidden capture and argmax update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        feat_d     = feat_q;
        hid_d      = hid_q;
        best_idx_d = best_idx_q;
        best_sc_d  = best_sc_q;
        pred_d     = pred_q;
        score_d    = score_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    feat_d  = features;
                    cnt_d   = '0;
                    state_d = S_L0;
                end
            end
            S_L0: begin
                for (int n = 0; n < HIDDEN_CNT; n++) begin
                    for (int p = 0; p < PAR; p++) begin
                        if (n == int'(cnt_q) * PAR + p) hid_d[n] = lane_h[p];
                    end
                end
                if (cnt_q == CW'(L0_CYC - 1)) begin
                    cnt_d      = '0;
                    best_idx_d = '0;
                    best_sc_d  = '0;
                    state_d    = S_L1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_L1: begin
                if (take) begin
                    best_idx_d = PW'(cnt_q);
                    best_sc_d  = cls_sc;
                end
                if (cnt_q == CW'(CLASS_CNT - 1)) begin
                    pred_d  = take ? PW'(cnt_q) : best_idx_q;
                    score_d = take ? cls_sc : best_sc_q;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset abandons any inference in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            feat_q     <= '0;
            hid_q      <= '0;
            best_idx_q <= '0;
            best_sc_q  <= '0;
            pred_q     <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            feat_q     <= feat_d;
            hid_q      <= hid_d;
            best_idx_q <= best_idx_d;
            best_sc_q  <= best_sc_d;
            pred_q     <= pred_d;
            score_q    <= score_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign prediction = pred_q;
    assign score      = score_q;

endmodule

// File: tb/tb_bnn_romex_pipe.sv
// Scoreboard bench: six engine variants driven in lockstep, each checked against a software model.
// Latency: every variant here completes in 2+3=5 cycles.
// Backpressure: out_ready is held low for a window to check the DONE hold behaviour.
module tb_bnn_romex_pipe;

    localparam int ND = 6;

    localparam logic [15:0] W0_T [ND] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h6C39, 16'h6C39};
    localparam logic [11:0] W1_T [ND] = '{12'h7F0, 12'h5A0, 12'hFF0, 12'h7F0, 12'hB4E, 12'hB4E};

    typedef struct packed {
        logic [ND-1:0][1:0] p;
        logic [ND-1:0][2:0] s;
        logic [31:0]        acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   features;
    logic          in_valid;
    logic          out_ready;
    logic [ND-1:0] in_rdy;
    logic [ND-1:0] out_vld;
    logic [1:0]    pred [ND];
    logic [2:0]    scr  [ND];
    logic [31:0]   cyc = '0;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_vld = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bnn_romex_pipe #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(2),
                     .Weights0(W0_T[0]), .Weights1(W1_T[0])) u_a (
        .clk(clk), .rst(rst), .features(features), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .out_valid(out_vld[0]), .out_ready(out_ready), .prediction(pred[0]), .score(scr[0]));
    bnn_romex_pipe #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(2),
                     .Weights0(W0_T[1]), .Weights1(W1_T[1])) u_b (
        .clk(clk), .rst(rst), .features(features), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .out_valid(out_vld[1]), .out_ready(out_ready), .prediction(pred[1]), .score(scr[1]));
    bnn_romex_pipe #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(2),
                     .Weights0(W0_T[2]), .Weights1(W1_T[2])) u_c (
        .clk(clk), .rst(rst), .features(features), .in_valid(in_valid), .in_ready(in_rdy[2]),
        .out_valid(out_vld[2]), .out_ready(out_ready), .prediction(pred[2]), .score(scr[2]));
    bnn_romex_pipe #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(3),
                     .Weights0(W0_T[3]), .Weights1(W1_T[3])) u_d (
        .clk(clk), .rst(rst), .features(features), .in_valid(in_valid), .in_ready(in_rdy[3]),
        .out_valid(out_vld[3]), .out_ready(out_ready), .prediction(pred[3]), .score(scr[3]));
    bnn_romex_pipe #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(2),
                     .Weights0(W0_T[4]), .Weights1(W1_T[4])) u_e (
        .clk(clk), .rst(rst), .features(features), .in_valid(in_valid), .in_ready(in_rdy[4]),
        .out_valid(out_vld[4]), .out_ready(out_ready), .prediction(pred[4]), .score(scr[4]));
    bnn_romex_pipe #(.FEAT_CNT(4), .FEAT_BITS(4), .HIDDEN_CNT(4), .CLASS_CNT(3), .PAR(3),
                     .Weights0(W0_T[5]), .Weights1(W1_T[5])) u_f (
        .clk(clk), .rst(rst), .features(features), .in_valid(in_valid), .in_ready(in_rdy[5]),
        .out_valid(out_vld[5]), .out_ready(out_ready), .prediction(pred[5]), .score(scr[5]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Golden model: {prediction[1:0], score[2:0]} for a 4x4x4x3 network.
    function automatic logic [4:0] model(input logic [15:0] w0, input logic [11:0] w1,
                                         input logic [15:0] f);
        logic [3:0] h;
        int acc, x, sc, best, bi;
        for (int n = 0; n < 4; n++) begin
            acc = 0;
            for (int k = 0; k < 4; k++) begin
                x = int'(f[k*4 +: 4]);
                acc = w0[n*4+k] ? acc + x : acc - x;
            end
            h[n] = (acc >= 0);
        end
        best = -1;
        bi   = 0;
        for (int c = 0; c < 3; c++) begin
            sc = 0;
            for (int n = 0; n < 4; n++) if (h[n] == w1[c*4+n]) sc++;
            if (sc > best) begin
                best = sc;
                bi   = c;
            end
        end
        return {bi[1:0], best[2:0]};
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] f);
        exp_t e;
        e = '0;
        for (int d = 0; d < ND; d++) {e.p[d], e.s[d]} = model(W0_T[d], W1_T[d], f);
        return e;
    endfunction

    task automatic send(input logic [15:0] f, input exp_t e);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_rdy[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy[0]) chk("in_ready wait", 32'(in_rdy[0]), 1);
        features = f;
        in_valid = 1'b1;
        e.acc    = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        features = 16'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sb.size()), 0);
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s in_ready[%0d]", tag, d), 32'(in_rdy[d]), 1);
            chk($sformatf("%s out_valid[%0d]", tag, d), 32'(out_vld[d]), 0);
        end
    endtask

    // Output monitor: latency on the rising edge of out_valid, compare on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld[0] && !prev_vld) begin
                if (sb.size() == 0) chk("spurious out_valid", 32'(out_vld[0]), 0);
                else                chk("latency", cyc - sb[0].acc, 5);
            end
            if (out_vld[0] && out_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("out_valid[%0d]", d), 32'(out_vld[d]), 1);
                    chk($sformatf("prediction[%0d]", d), 32'(pred[d]), 32'(mon_e.p[d]));
                    chk($sformatf("score[%0d]", d), 32'(scr[d]), 32'(mon_e.s[d]));
                end
            end
        end
        prev_vld = out_vld[0];
    end

    initial begin
        exp_t e;
        logic [15:0] f;
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        features  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset prediction[%0d]", d), 32'(pred[d]), 0);
            chk($sformatf("reset score[%0d]", d), 32'(scr[d]), 0);
        end

        // All-ones W0: h=1111, class 1 wins with 4 (PAR=2 and PAR=3); tie c1=c2 resolves to 1.
        f = 16'h3A7C;
        e = mk_exp(f);
        e.p[0] = 2'd1; e.s[0] = 3'd4;
        e.p[2] = 2'd1; e.s[2] = 3'd4;
        e.p[3] = 2'd1; e.s[3] = 3'd4;
        send(f, e);
        drain();

        // All-zero W0 with full-scale features: acc=-60, h=0000, class 0 wins with 4.
        f = 16'hFFFF;
        e = mk_exp(f);
        e.p[1] = 2'd0; e.s[1] = 3'd4;
        send(f, e);
        drain();

        // Zero features: acc=0 counts positive, so h=1111 on every variant.
        f = 16'h0000;
        e = mk_exp(f);
        e.p[0] = 2'd1; e.s[0] = 3'd4;
        e.p[1] = 2'd1; e.s[1] = 3'd2;
        e.p[2] = 2'd1; e.s[2] = 3'd4;
        send(f, e);
        drain();

        // Backpressure: hold the result 10 cycles while in_valid pulses.
        out_ready = 1'b0;
        f = 16'h9E15;
        e = mk_exp(f);
        send(f, e);
        t = 0;
        while (!out_vld[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("hold out_valid[%0d]", d), 32'(out_vld[d]), 1);
                chk($sformatf("hold in_ready[%0d]", d), 32'(in_rdy[d]), 0);
                chk($sformatf("hold prediction[%0d]", d), 32'(pred[d]), 32'(e.p[d]));
                chk($sformatf("hold score[%0d]", d), 32'(scr[d]), 32'(e.s[d]));
            end
            in_valid = ~in_valid;
            features = 16'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_idle("release");
        drain();

        // Reset pulse while in L1 aborts the inference.
        send(16'h1234, mk_exp(16'h1234));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk_idle("abort");
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("abort prediction[%0d]", d), 32'(pred[d]), 0);
            chk($sformatf("abort score[%0d]", d), 32'(scr[d]), 0);
        end
        send(16'hC0DE, mk_exp(16'hC0DE));
        drain();

        // Random sweep against the model.
        for (int i = 0; i < 1000; i++) begin
            f = 16'($urandom);
            send(f, mk_exp(f));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
